// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: active-low glyphs and FSM states.
package seg_pkg;

    // Active-low segment patterns, segments a..g on bits 6..0.
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/segment7.sv
// Nibble to active-low 7-segment glyph; non-BCD codes produce a dark digit.
module segment7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Pure lookup; anything outside 0..9 stays dark.
    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display driver with dead-time, leading-zero
// blanking and a per-frame snapshot so one frame never mixes two values.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int LZ_BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    scan_state_t                state;
    scan_state_t                state_nxt;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              cnt_nxt;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_nxt;
    logic                       capture;
    logic                       frame_end;

    logic [DIGITS-1:0][3:0]     bcd_snap;
    logic [DIGITS-1:0]          dp_snap;
    logic [DIGITS-1:0]          blank_mask;
    logic                       upper_zero;
    logic [6:0]                 glyph;

    logic [6:0]                 seg_d;
    logic                       dp_d;
    logic [DIGITS-1:0]          dig_d;
    logic                       tick_d;

    // Glyph for whichever digit the scan is currently on.
    segment7 u_dec (
        .nibble (bcd_snap[idx]),
        .seg_n  (glyph)
    );

    // Leading-zero mask from the frozen snapshot, walking down from the top digit.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (bcd_snap[k] == 4'd0);
            blank_mask[k] = (LZ_BLANK != 0) && upper_zero && !dp_snap[k];
        end
    end

    // Next-state, slot counter and digit index; capture marks snapshot points.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        capture   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                capture   = 1'b1;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = SCAN;
            end
            SCAN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        capture   = 1'b1;
                        frame_end = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the next cycle; an en drop blanks on the very next edge.
    always_comb begin
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        dig_d  = '1;
        tick_d = 1'b0;
        if (state == SCAN && en) begin
            tick_d = frame_end;
            if (cnt >= BLANK_END && !blank_mask[idx]) begin
                seg_d      = glyph;
                dp_d       = ~dp_snap[idx];
                dig_d[idx] = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot counter, digit index and the frame snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            idx      <= '0;
            bcd_snap <= '0;
            dp_snap  <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            if (capture) begin
                bcd_snap <= bcd_in;
                dp_snap  <= dp_in;
            end
        end
    end

    // Registered pad drivers so the display lines never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            dig_n      <= dig_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle model pushes expected pad values
// on each rising edge, a checker pops and compares them on the falling edge.
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       tick;
    } outs_t;

    typedef struct packed {
        outs_t lz;
        outs_t nolz;
    } exp_t;

    logic        clk;
    logic        clk_run;
    logic        rstn;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;

    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    logic [6:0]  nolz_seg_n;
    logic        nolz_dp_n;
    logic [3:0]  nolz_dig_n;
    logic        nolz_frame_tick;

    int          tests_run;
    int          failures;

    int          m_state;
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    exp_t        sb_q[$];
    exp_t        push_e;
    exp_t        pop_e;

    seg_scan_driver #(
        .DIGITS    (D),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .LZ_BLANK  (1)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    seg_scan_driver #(
        .DIGITS    (D),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .LZ_BLANK  (0)
    ) u_dut_nolz (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg_n      (nolz_seg_n),
        .dp_n       (nolz_dp_n),
        .dig_n      (nolz_dig_n),
        .frame_tick (nolz_frame_tick)
    );

    // Gateable clock so reset can be asserted with the clock frozen.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Pad values the display should show right after the coming edge.
    function automatic outs_t model_out(input bit lz);
        outs_t      o;
        logic [3:0] nib;
        bit         blank;
        o.seg  = 7'h7F;
        o.dp   = 1'b1;
        o.dig  = 4'hF;
        o.tick = 1'b0;
        if (m_state == 2 && en) begin
            o.tick = (m_cnt == SD - 1) && (m_idx == D - 1);
            nib    = m_bcd[4*m_idx +: 4];
            blank  = lz && (m_idx != 0) && ((m_bcd >> (4*m_idx)) == 16'd0) && !m_dp[m_idx];
            if (m_cnt >= BC && !blank) begin
                o.seg        = glyph(nib);
                o.dp         = ~m_dp[m_idx];
                o.dig[m_idx] = 1'b0;
            end
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one step per rising edge, reset on rstn low.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_state = 0;
                m_cnt   = 0;
                m_idx   = 0;
                m_bcd   = '0;
                m_dp    = '0;
                sb_q.delete();
            end else begin
                push_e.lz   = model_out(1'b1);
                push_e.nolz = model_out(1'b0);
                sb_q.push_back(push_e);
                case (m_state)
                    0: if (en) m_state = 1;
                    1: begin
                        m_bcd   = bcd_in;
                        m_dp    = dp_in;
                        m_cnt   = 0;
                        m_idx   = 0;
                        m_state = 2;
                    end
                    default: begin
                        if (!en) begin
                            m_state = 0;
                        end else if (m_cnt == SD - 1) begin
                            m_cnt = 0;
                            if (m_idx == D - 1) begin
                                m_idx = 0;
                                m_bcd = bcd_in;
                                m_dp  = dp_in;
                            end else begin
                                m_idx++;
                            end
                        end else begin
                            m_cnt++;
                        end
                    end
                endcase
            end
        end
    end

    // Scoreboard checker on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                pop_e = sb_q.pop_front();
                checkOutput("seg_n",           seg_n,           pop_e.lz.seg);
                checkOutput("dp_n",            dp_n,            pop_e.lz.dp);
                checkOutput("dig_n",           dig_n,           pop_e.lz.dig);
                checkOutput("frame_tick",      frame_tick,      pop_e.lz.tick);
                checkOutput("nolz_seg_n",      nolz_seg_n,      pop_e.nolz.seg);
                checkOutput("nolz_dp_n",       nolz_dp_n,       pop_e.nolz.dp);
                checkOutput("nolz_dig_n",      nolz_dig_n,      pop_e.nolz.dig);
                checkOutput("nolz_frame_tick", nolz_frame_tick, pop_e.nolz.tick);
            end
        end
    end

    task automatic applyStimulus(input logic e, input logic [15:0] bcd, input logic [3:0] dp, input int cycles);
        en     = e;
        bcd_in = bcd;
        dp_in  = dp;
        repeat (cycles) @(negedge clk);
    endtask

    // Wait (bounded) for a given digit enable pattern, then check its glyph.
    task automatic waitDigit(input string tag, input logic [3:0] dig, input logic [6:0] seg, input logic dpn);
        int n = 0;
        while (dig_n !== dig && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_found"}, 32'(n < 200), 32'd1);
        if (n < 200) begin
            checkOutput({tag, "_seg"}, seg_n, seg);
            checkOutput({tag, "_dp"}, dp_n, dpn);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ticks;
        tests_run = 0;
        failures  = 0;
        clk_run   = 1'b1;
        rstn      = 1'b0;
        en        = 1'b0;
        bcd_in    = '0;
        dp_in     = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        applyStimulus(1'b0, 16'h0000, 4'h0, 3);

        // Basic scan of 1234.
        applyStimulus(1'b1, 16'h1234, 4'h0, 2);
        waitDigit("d0", 4'b1110, 7'b1001100, 1'b1);
        waitDigit("d1", 4'b1101, 7'b0000110, 1'b1);
        waitDigit("d2", 4'b1011, 7'b0010010, 1'b1);
        waitDigit("d3", 4'b0111, 7'b1001111, 1'b1);

        ticks = 0;
        repeat (64) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        checkOutput("tick_count", ticks, 2);

        // Coherence: change value mid-frame.
        waitDigit("coh_d1", 4'b1101, 7'b0000110, 1'b1);
        bcd_in = 16'h5678;
        waitDigit("coh_d2", 4'b1011, 7'b0010010, 1'b1);
        waitDigit("coh_d3", 4'b0111, 7'b1001111, 1'b1);
        waitDigit("coh_n0", 4'b1110, 7'b0000000, 1'b1);
        waitDigit("coh_n1", 4'b1101, 7'b0001111, 1'b1);
        waitDigit("coh_n2", 4'b1011, 7'b0100000, 1'b1);
        waitDigit("coh_n3", 4'b0111, 7'b0100100, 1'b1);

        // Leading zeros and all-zero.
        applyStimulus(1'b1, 16'h0070, 4'h0, 80);
        applyStimulus(1'b1, 16'h0000, 4'h0, 70);

        // Non-BCD nibble with its decimal point.
        applyStimulus(1'b1, 16'h0A00, 4'b0100, 40);
        waitDigit("hexA", 4'b1011, 7'b1111111, 1'b0);

        // Decimal point keeps an otherwise leading zero lit.
        applyStimulus(1'b1, 16'h0005, 4'b1000, 40);
        waitDigit("dp3", 4'b0111, 7'b0000001, 1'b0);

        // Enable drop in digit 2, then restart through LOAD.
        applyStimulus(1'b1, 16'h1234, 4'h0, 40);
        waitDigit("pre_off", 4'b1011, 7'b0010010, 1'b1);
        applyStimulus(1'b0, 16'h1234, 4'h0, 1);
        checkOutput("off_dig", dig_n, 4'hF);
        checkOutput("off_seg", seg_n, 7'h7F);
        applyStimulus(1'b0, 16'h1234, 4'h0, 4);
        applyStimulus(1'b1, 16'h0009, 4'h0, 0);
        waitDigit("restart", 4'b1110, 7'b0000100, 1'b1);
        applyStimulus(1'b1, 16'h0009, 4'h0, 20);

        // Async reset mid-slot with the clock frozen.
        waitDigit("pre_rst", 4'b1110, 7'b0000100, 1'b1);
        clk_run = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_seg",  seg_n,      7'h7F);
        checkOutput("rst_dp",   dp_n,       1'b1);
        checkOutput("rst_dig",  dig_n,      4'hF);
        checkOutput("rst_tick", frame_tick, 1'b0);
        checkOutput("rst_nolz_dig", nolz_dig_n, 4'hF);
        #2;
        rstn    = 1'b1;
        clk_run = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 16'h4321, 4'b0001, 40);
        applyStimulus(1'b0, 16'h4321, 4'b0001, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
